// File: rtl/micro_sequencer.sv
// micro_sequencer -- MIC-1 microprogram sequencer.
//
// Fetches 36-bit microinstructions from an external control store at address
// MPC and executes each one in two cycles: FETCH latches the word into MIR,
// and EXEC fires the C-bus and memory strobes, latches the ULA flags and
// advances MPC. A memory stall holds EXEC with all strobes suppressed.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   run                   start sequencing from IDLE
//   stall                 memory wait, freezes EXEC
//   cs_addr[8:0]          control-store address (MPC)
//   cs_data[35:0]         microinstruction at cs_addr
//   ula_select[7:0]       MIR ALU field to the ULA
//   ula_n, ula_z          live ULA flags
//   mbr[7:0]              MBR value used by JMPC
//   c_en[8:0]             C-bus write enables
//   b_sel[3:0]            B-bus source
//   mem_wr/mem_rd/mem_fetch  memory strobes
//   n_flag, z_flag        latched ULA flags
//   busy                  high in FETCH or EXEC
//
// Configuration: define MIC1_SEQ_JMPC_EN to enable JMPC (mbr ORed into the
// low eight bits of the next address). Without it JMPC and mbr are ignored.

module micro_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        stall,
    output logic [8:0]  cs_addr,
    input  logic [35:0] cs_data,
    output logic [7:0]  ula_select,
    input  logic        ula_n,
    input  logic        ula_z,
    input  logic [7:0]  mbr,
    output logic [8:0]  c_en,
    output logic [3:0]  b_sel,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic        mem_fetch,
    output logic        n_flag,
    output logic        z_flag,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      state;
    logic [8:0]  mpc;
    logic [35:0] mir;

    logic [7:0]  jmpc_mask;
    logic [8:0]  next_addr;
    logic        exec_fire;

`ifdef MIC1_SEQ_JMPC_EN
    assign jmpc_mask = mir[26] ? mbr : 8'h00;
`else
    // JMPC bit and mbr are intentionally unused in this build.
    logic unused_jmpc;
    assign unused_jmpc = &{1'b0, mir[26], mbr};
    assign jmpc_mask   = 8'h00;
`endif

    // Jumps are ORs into the address, never adds: JAMN/JAMZ can only set bit 8.
    assign next_addr = {mir[35] | (mir[25] & ula_n) | (mir[24] & ula_z),
                        mir[34:27] | jmpc_mask};

    // Strobes depend on the live stall input, so they are decoded from the
    // registered state rather than registered themselves; reset masks them so
    // nothing fires in the cycle reset is asserted.
    assign exec_fire = (state == EXEC) && !stall && !reset;

    assign cs_addr    = mpc;
    assign ula_select = reset ? 8'h00 : mir[23:16];
    assign b_sel      = reset ? 4'h0  : mir[3:0];
    assign c_en       = exec_fire ? mir[15:7] : 9'h000;
    assign mem_wr     = exec_fire & mir[6];
    assign mem_rd     = exec_fire & mir[5];
    assign mem_fetch  = exec_fire & mir[4];
    assign busy       = !reset && (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mpc    <= 9'h000;
            mir    <= 36'h0;
            n_flag <= 1'b0;
            z_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run)
                        state <= FETCH;
                end
                FETCH: begin
                    mir   <= cs_data;
                    state <= EXEC;
                end
                EXEC: begin
                    if (!stall) begin
                        n_flag <= ula_n;
                        z_flag <= ula_z;
                        mpc    <= next_addr;
                        state  <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
